// File: rtl/alu_acc_flags.sv
// ALU writeback stage: registers the ALU result into the accumulator, captures
// {N,V,C,Z} status flags and evaluates the branch condition from the stored flags.
module alu_acc_flags #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_carry,
    input  logic                  alu_overflow,
    input  logic [2:0]            alu_func,
    input  logic                  acc_we,
    input  logic                  flags_we,
    input  logic                  flags_load,
    input  logic [3:0]            flags_in,
    input  logic [2:0]            cond_sel,
    output logic [DATA_WIDTH-1:0] acc,
    output logic [3:0]            flags,
    output logic                  cond_true
);

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [2:0] FUNC_SUB  = 3'b001;
    localparam logic [2:0] FUNC_RSVD = 3'b011;

    localparam int FN = 3;
    localparam int FV = 2;
    localparam int FC = 1;
    localparam int FZ = 0;

    logic [3:0] flags_next;
    logic       arith_op;

    assign arith_op = (alu_func == FUNC_ADD) || (alu_func == FUNC_SUB);

    // Restore wins over ALU update; flags are derived from this cycle's alu_out, not acc.
    always_comb begin
        flags_next = flags;
        if (flags_load) begin
            flags_next = flags_in;
        end else if (flags_we && (alu_func != FUNC_RSVD)) begin
            flags_next[FN] = alu_out[DATA_WIDTH-1];
            flags_next[FZ] = (alu_out == '0);
            if (arith_op) begin
                flags_next[FC] = alu_carry;
                flags_next[FV] = alu_overflow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            flags <= 4'b0000;
        end else begin
            if (acc_we) begin
                acc <= alu_out;
            end
            flags <= flags_next;
        end
    end

    always_comb begin
        cond_true = 1'b1;
        case (cond_sel)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = flags[FZ];
            3'b010:  cond_true = ~flags[FZ];
            3'b011:  cond_true = flags[FC];
            3'b100:  cond_true = ~flags[FC];
            3'b101:  cond_true = flags[FN];
            3'b110:  cond_true = flags[FV];
            3'b111:  cond_true = ~flags[FN];
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_alu_acc_flags.sv
// Bench for alu_acc_flags: directed scenarios plus randomized cycles against a
// rule-level reference model of accumulator, flags and branch conditions.
module tb_alu_acc_flags;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_overflow;
    logic [2:0] alu_func;
    logic       acc_we;
    logic       flags_we;
    logic       flags_load;
    logic [3:0] flags_in;
    logic [2:0] cond_sel;
    logic [7:0] acc;
    logic [3:0] flags;
    logic       cond_true;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] m_acc;
    logic       m_n, m_v, m_c, m_z;

    alu_acc_flags #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow), .alu_func(alu_func), .acc_we(acc_we),
        .flags_we(flags_we), .flags_load(flags_load), .flags_in(flags_in),
        .cond_sel(cond_sel), .acc(acc), .flags(flags), .cond_true(cond_true)
    );

    always #10 clk = ~clk;

    task automatic idle();
        reset = 0; alu_out = 0; alu_carry = 0; alu_overflow = 0; alu_func = 3'b010;
        acc_we = 0; flags_we = 0; flags_load = 0; flags_in = 0; cond_sel = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies the behavioural rules for one clock edge using the currently driven inputs.
    task automatic model_edge();
        if (reset) begin
            m_acc = 0; {m_n, m_v, m_c, m_z} = 4'b0000;
        end else begin
            if (acc_we) m_acc = alu_out;
            if (flags_load) begin
                {m_n, m_v, m_c, m_z} = flags_in;
            end else if (flags_we && alu_func != 3'b011) begin
                m_n = alu_out[7];
                m_z = (alu_out == 8'h00);
                if (alu_func == 3'b000 || alu_func == 3'b001) begin
                    m_c = alu_carry;
                    m_v = alu_overflow;
                end
            end
        end
    endtask

    function automatic logic model_cond(input logic [2:0] sel);
        logic tab [8];
        tab = '{1'b1, m_z, !m_z, m_c, !m_c, m_n, m_v, !m_n};
        return tab[sel];
    endfunction

    task automatic test_reset();
        idle();
        reset = 1; acc_we = 1; alu_out = 8'hFF; flags_we = 1; alu_func = 3'b000;
        step();
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc got %h want 00", acc); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
        idle();
        cond_sel = 3'b000; #1;
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL reset_cond000 got %b want 1", cond_true); end
        cond_sel = 3'b001; #1;
        checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL reset_cond001 got %b want 0", cond_true); end
    endtask

    task automatic test_add_overflow();
        idle();
        alu_func = 3'b000; alu_out = 8'h80; alu_carry = 0; alu_overflow = 1; acc_we = 1; flags_we = 1;
        step();
        idle();
        checks++; if (acc !== 8'h80) begin errors++; $display("FAIL add_acc got %h want 80", acc); end
        checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL add_flags got %b want 1100", flags); end
        cond_sel = 3'b110; #1;
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL add_cond110 got %b want 1", cond_true); end
    endtask

    task automatic test_sub_zero();
        idle();
        alu_func = 3'b001; alu_out = 8'h00; alu_carry = 1; alu_overflow = 0; acc_we = 1; flags_we = 1;
        step();
        idle();
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL sub_acc got %h want 00", acc); end
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL sub_flags got %b want 0011", flags); end
        cond_sel = 3'b001; #1;
        checks++; if (cond_true !== 1'b1) begin errors++; $display("FAIL sub_cond001 got %b want 1", cond_true); end
        cond_sel = 3'b100; #1;
        checks++; if (cond_true !== 1'b0) begin errors++; $display("FAIL sub_cond100 got %b want 0", cond_true); end
    endtask

    task automatic test_logic_hold();
        idle();
        flags_load = 1; flags_in = 4'b0010;
        step();
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL logic_setup got %b want 0010", flags); end
        idle();
        alu_func = 3'b010; alu_out = 8'h00; alu_carry = 0; alu_overflow = 1; flags_we = 1;
        step();
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL logic_hold got %b want 0011", flags); end
        // reserved function leaves every flag untouched even with a negative result
        alu_func = 3'b011; alu_out = 8'h80; alu_carry = 0; alu_overflow = 1;
        step();
        checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL rsvd_hold got %b want 0011", flags); end
        // NOT-style op on a negative result updates N and Z only
        alu_func = 3'b111; alu_out = 8'hF0;
        step();
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL not_flags got %b want 1010", flags); end
    endtask

    task automatic test_priority();
        idle();
        flags_load = 1; flags_in = 4'b1010; flags_we = 1; alu_func = 3'b000; alu_out = 8'h00;
        alu_carry = 1; alu_overflow = 0;
        step();
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL prio_load got %b want 1010", flags); end
        idle();
        alu_out = 8'h77;
        step();
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL prio_hold got %b want 1010", flags); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL acc_hold got %h want 00", acc); end
    endtask

    task automatic test_reset_mid();
        idle();
        acc_we = 1; alu_out = 8'h5A; flags_load = 1; flags_in = 4'b1111;
        step();
        checks++; if (acc !== 8'h5A) begin errors++; $display("FAIL mid_setup_acc got %h want 5a", acc); end
        checks++; if (flags !== 4'b1111) begin errors++; $display("FAIL mid_setup_flags got %b want 1111", flags); end
        idle();
        reset = 1; acc_we = 1; alu_out = 8'h33; flags_load = 1; flags_in = 4'b1111;
        step();
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL mid_reset_acc got %h want 00", acc); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL mid_reset_flags got %b want 0000", flags); end
        idle();
    endtask

    task automatic test_random();
        idle();
        reset = 1; model_edge(); step();
        for (int i = 0; i < 300; i++) begin
            reset        = ($urandom_range(0, 31) == 0);
            alu_out      = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            alu_carry    = 1'($urandom);
            alu_overflow = 1'($urandom);
            alu_func     = 3'($urandom);
            acc_we       = 1'($urandom);
            flags_we     = ($urandom_range(0, 3) != 0);
            flags_load   = ($urandom_range(0, 7) == 0);
            flags_in     = 4'($urandom);
            model_edge();
            step();
            checks++; if (acc !== m_acc) begin errors++; $display("FAIL rnd_acc cyc %0d got %h want %h", i, acc, m_acc); end
            checks++; if (flags !== {m_n, m_v, m_c, m_z}) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b want %b", i, flags, {m_n, m_v, m_c, m_z});
            end
            for (int s = 0; s < 8; s++) begin
                cond_sel = 3'(s);
                #1;
                checks++; if (cond_true !== model_cond(3'(s))) begin
                    errors++; $display("FAIL rnd_cond cyc %0d sel %0d got %b want %b", i, s, cond_true, model_cond(3'(s)));
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        #3;
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_logic_hold();
        test_priority();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
